// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm -- frame controller / serializer of the UART TX path.
//
// Accepts a parallel word on Data_Valid while idle and sends it on TX_OUT as
// start bit (0), DATA_W data bits LSB first, an optional parity bit taken live
// from the parity stage, and a stop bit (1). One bit per clk cycle; clk is the
// baud clock. Outputs are decoded from registered state only (plus the shift
// register LSB and, in the parity cycle, par_bit), so there is no path from
// Data_Valid/P_DATA/PAR_EN to the outputs.
//
// Build option:
//   UART_TX_TWO_STOP_EN  defined: a second stop cycle (STOP2) follows STOP and
//                        tx_done moves to STOP2. Undefined: single stop bit.
//
// Parameters:
//   DATA_W      data bits per frame (5..9)
// Ports:
//   clk         baud clock, all state on rising edge
//   RST         asynchronous active-high reset
//   P_DATA      parallel word, sampled only when a frame is accepted
//   Data_Valid  word valid, accepted only in IDLE
//   PAR_EN      parity enable, sampled only when a frame is accepted
//   par_bit     parity bit from the parity stage, used in the PARITY cycle
//   TX_OUT      serial line, idle high
//   busy        high from START through the last stop cycle
//   tx_done     one-cycle pulse during the final stop cycle
module uart_tx_fsm #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              Data_Valid,
  input  logic              PAR_EN,
  input  logic              par_bit,
  output logic              TX_OUT,
  output logic              busy,
  output logic              tx_done
);

  // Counter reaches DATA_W after the last data bit, so it needs one spare code.
  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`endif

  state_t            state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [CNT_W-1:0]  cnt_r,   cnt_s;
  logic              par_en_r, par_en_s;

  // State and datapath registers; reset returns the line to idle immediately.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      shift_r  <= '0;
      cnt_r    <= '0;
      par_en_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      cnt_r    <= cnt_s;
      par_en_r <= par_en_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    cnt_s    = cnt_r;
    par_en_s = par_en_r;
    case (state_r)
      ST_IDLE: begin
        // P_DATA/PAR_EN are only looked at on acceptance, so X on them
        // while Data_Valid is low never reaches the registers.
        if (Data_Valid) begin
          shift_s  = P_DATA;
          par_en_s = PAR_EN;
          cnt_s    = '0;
          state_s  = ST_START;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_DATA;
      end
      ST_DATA: begin
        shift_s = {1'b0, shift_r[DATA_W-1:1]};
        cnt_s   = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          if (par_en_r) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_STOP;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        state_s = ST_STOP;
      end
`ifdef UART_TX_TWO_STOP_EN
      ST_STOP: begin
        state_s = ST_STOP2;
      end
      ST_STOP2: begin
        state_s = ST_IDLE;
      end
`else
      ST_STOP: begin
        state_s = ST_IDLE;
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    TX_OUT  = 1'b1;
    busy    = 1'b0;
    tx_done = 1'b0;
    case (state_r)
      ST_IDLE: begin
        TX_OUT = 1'b1;
        busy   = 1'b0;
      end
      ST_START: begin
        TX_OUT = 1'b0;
        busy   = 1'b1;
      end
      ST_DATA: begin
        TX_OUT = shift_r[0];
        busy   = 1'b1;
      end
      ST_PARITY: begin
        // par_bit is held stable upstream while busy is high.
        TX_OUT = par_bit;
        busy   = 1'b1;
      end
`ifdef UART_TX_TWO_STOP_EN
      ST_STOP: begin
        TX_OUT = 1'b1;
        busy   = 1'b1;
      end
      ST_STOP2: begin
        TX_OUT  = 1'b1;
        busy    = 1'b1;
        tx_done = 1'b1;
      end
`else
      ST_STOP: begin
        TX_OUT  = 1'b1;
        busy    = 1'b1;
        tx_done = 1'b1;
      end
`endif
      default: begin
        TX_OUT  = 1'b1;
        busy    = 1'b0;
        tx_done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm. A reference model expands every
// accepted word into its expected per-cycle line activity and queues it; a
// monitor on the falling clock edge pops one expectation per cycle and
// compares busy, TX_OUT and tx_done. Directed frames additionally check the
// captured serial pattern against literal frames.
`timescale 1ns/1ps
module tb_uart_tx_fsm;
  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          par_bit = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          TX_OUT, busy, tx_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic busy;
    logic tx;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   rem = 0;

  uart_tx_fsm #(.DATA_W(DW)) dut (
    .clk        (clk),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic b, logic t, logic d);
    exp_t e;
    e.busy = b;
    e.tx   = t;
    e.done = d;
    return e;
  endfunction

  // Expand one frame: start, data LSB first, optional parity, stop bit(s).
  function automatic void push_frame(logic [DW-1:0] d, logic pe, logic pb);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
    for (int i = 0; i < DW; i++) exp_q.push_back(mk(1'b1, d[i], 1'b0));
    if (pe) exp_q.push_back(mk(1'b1, pb, 1'b0));
    for (int s = 0; s < NSTOP; s++) exp_q.push_back(mk(1'b1, 1'b1, (s == NSTOP - 1)));
  endfunction

  // Reference model: one queued expectation per clock cycle.
  always @(posedge clk or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
      rem = 0;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
    end else if (Data_Valid === 1'b1) begin
      push_frame(P_DATA, PAR_EN, par_bit);
      rem = 1 + DW + (PAR_EN ? 1 : 0) + NSTOP;
    end else begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
    end
  end

  // Monitor: compare the line against the model every cycle.
  always @(negedge clk) begin
    if (RST) begin
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle actual tx=%b busy=%b done=%b expected tx=1 busy=0 done=0",
                 TX_OUT, busy, tx_done);
      end
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow actual tx=%b busy=%b done=%b expected queued entry", TX_OUT, busy, tx_done);
    end else begin
      mon_e = exp_q.pop_front();
      checks++;
      if (busy !== mon_e.busy || TX_OUT !== mon_e.tx || tx_done !== mon_e.done) begin
        errors++;
        $display("FAIL sb_cycle t=%0t actual busy=%b tx=%b done=%b expected busy=%b tx=%b done=%b",
                 $time, busy, TX_OUT, tx_done, mon_e.busy, mon_e.tx, mon_e.done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Present a word for one acceptance edge; leaves us inside the START cycle.
  task automatic accept_word(input logic [DW-1:0] d, input logic pe, input logic pb, input bit hold);
    @(posedge clk); #1;
    P_DATA = d; PAR_EN = pe; par_bit = pb; Data_Valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) Data_Valid = 1'b0;
  endtask

  // Capture TX_OUT while busy, first bit ends up most significant.
  task automatic collect(output logic [31:0] bits, output int len, input bit scramble);
    bits = '0;
    len  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      bits = {bits[30:0], TX_OUT};
      len++;
      if (scramble) begin
        P_DATA = DW'($urandom);
        PAR_EN = 1'($urandom_range(0, 1));
      end
    end
  endtask

  logic [31:0] bits;
  int          len;
  logic [31:0] exp_a5, exp_0f, exp_55, exp_33;

  initial begin
`ifdef UART_TX_TWO_STOP_EN
    exp_a5 = 32'b010100101011;
    exp_0f = 32'b01111000011;
    exp_55 = 32'b010101010011;
    exp_33 = 32'b01100110011;
`else
    exp_a5 = 32'b01010010101;
    exp_0f = 32'b0111100001;
    exp_55 = 32'b01010101001;
    exp_33 = 32'b0110011001;
`endif
    // Reset with no clock edge yet.
    #1 RST = 1'b1;
    #1;
    chk("rst_tx", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    RST = 1'b0;

    // A5 with parity 0; inputs scrambled mid-frame.
    accept_word(8'hA5, 1'b1, 1'b0, 1'b0);
    collect(bits, len, 1'b1);
    chk("a5_len", 32'(len), 32'(1 + DW + 1 + NSTOP));
    chk("a5_bits", bits, exp_a5);

    // 0F without parity.
    accept_word(8'h0F, 1'b0, 1'b0, 1'b0);
    collect(bits, len, 1'b0);
    chk("0f_len", 32'(len), 32'(1 + DW + NSTOP));
    chk("0f_bits", bits, exp_0f);

    // Back-to-back with Data_Valid held; word/parity enable change mid-frame.
    accept_word(8'h55, 1'b1, 1'b0, 1'b1);
    P_DATA = 8'h33;
    PAR_EN = 1'b0;
    collect(bits, len, 1'b0);
    chk("b2b_first", bits, exp_55);
    chk("b2b_gap_tx", 32'(TX_OUT), 32'd1);
    @(posedge clk); #1;
    Data_Valid = 1'b0;
    collect(bits, len, 1'b0);
    chk("b2b_second", bits, exp_33);

    // Reset during the 4th data bit of FF.
    accept_word(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 RST = 1'b1;
    #1;
    chk("midrst_tx", 32'(TX_OUT), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(tx_done), 32'd0);
    @(posedge clk); #1;
    RST = 1'b0;
    accept_word(8'h0F, 1'b0, 1'b1, 1'b0);
    collect(bits, len, 1'b0);
    chk("postrst_bits", bits, exp_0f);

    // Randomized traffic, including held Data_Valid and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        #2 RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
      end
      Data_Valid = ($urandom_range(0, 2) == 0);
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom_range(0, 1));
      if (rem == 0) par_bit = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    Data_Valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
